// File: rtl/ucie_ctl_phy_wr_bridge.sv
// rtl/ucie_ctl_phy_wr_bridge.sv - PHY write-forward FIFO with ordered retrain request/ack
module ucie_ctl_phy_wr_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_phy_WR,
    input  logic [ADDR_WIDTH-1:0]         i_phy_addr,
    input  logic [DATA_WIDTH-1:0]         i_phy_WDATA,
    input  logic                          i_retrain,
    output logic                          o_pv_valid,
    output logic [ADDR_WIDTH-1:0]         o_pv_addr,
    output logic [DATA_WIDTH-1:0]         o_pv_data,
    input  logic                          i_pv_ready,
    output logic                          o_retrain_req,
    input  logic                          i_retrain_ack,
    output logic                          o_fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    input  logic                          i_ovf_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REQ} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, drain_cnt, drain_cnt_nxt;
    logic                  retrain_prev;
    logic                  push, pop, drop, retrain_rise;

    // Handshake qualifiers; a pop frees a slot for a same-cycle push into a full FIFO
    always_comb begin
        pop          = o_pv_valid & i_pv_ready;
        push         = i_phy_WR & ((count < CW'(FIFO_DEPTH)) | pop);
        drop         = i_phy_WR & ~push;
        retrain_rise = i_retrain & ~retrain_prev;
    end

    assign o_pv_valid    = (count != '0) & (state != S_REQ);
    assign o_pv_addr     = mem_addr[rd_ptr];
    assign o_pv_data     = mem_data[rd_ptr];
    assign o_retrain_req = (state == S_REQ);
    assign o_fifo_full   = (count == CW'(FIFO_DEPTH));
    assign o_count       = count;

    // FIFO storage, pointers and occupancy; storage cleared so the head reads 0 after reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_addr[wr_ptr] <= i_phy_addr;
                mem_data[wr_ptr] <= i_phy_WDATA;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
        end
    end

    // Retrain state register and edge-detect history
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            drain_cnt    <= '0;
            retrain_prev <= 1'b0;
        end else begin
            state        <= state_nxt;
            drain_cnt    <= drain_cnt_nxt;
            retrain_prev <= i_retrain;
        end
    end

    // Retrain sequencing: snapshot occupancy on the edge, wait for those entries to leave, then request
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            S_IDLE: begin
                if (retrain_rise) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = count + CW'(push) - CW'(pop);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = S_REQ;
                end else if (pop) begin
                    drain_cnt_nxt = drain_cnt - CW'(1);
                end
            end
            S_REQ: begin
                if (i_retrain_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ucie_ctl_phy_wr_bridge.sv
// tb/tb_ucie_ctl_phy_wr_bridge.sv - directed self-checking bench for ucie_ctl_phy_wr_bridge
module tb_ucie_ctl_phy_wr_bridge;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_phy_WR;
    logic [7:0]  i_phy_addr;
    logic [31:0] i_phy_WDATA;
    logic        i_retrain;
    logic        o_pv_valid;
    logic [7:0]  o_pv_addr;
    logic [31:0] o_pv_data;
    logic        i_pv_ready;
    logic        o_retrain_req;
    logic        i_retrain_ack;
    logic        o_fifo_full;
    logic [2:0]  o_count;
    logic        o_overflow;
    logic        i_ovf_clr;

    int errors = 0;
    int checks = 0;

    ucie_ctl_phy_wr_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_phy_WR(i_phy_WR), .i_phy_addr(i_phy_addr), .i_phy_WDATA(i_phy_WDATA),
        .i_retrain(i_retrain),
        .o_pv_valid(o_pv_valid), .o_pv_addr(o_pv_addr), .o_pv_data(o_pv_data),
        .i_pv_ready(i_pv_ready),
        .o_retrain_req(o_retrain_req), .i_retrain_ack(i_retrain_ack),
        .o_fifo_full(o_fifo_full), .o_count(o_count),
        .o_overflow(o_overflow), .i_ovf_clr(i_ovf_clr)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        i_phy_WR    = 1'b1;
        i_phy_addr  = a;
        i_phy_WDATA = d;
    endtask

    task automatic idle_wr();
        i_phy_WR    = 1'b0;
        i_phy_addr  = '0;
        i_phy_WDATA = '0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_phy_WR = 1'b0; i_phy_addr = '0; i_phy_WDATA = '0;
        i_retrain = 1'b0; i_pv_ready = 1'b0; i_retrain_ack = 1'b0; i_ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_count", o_count, 0);
        chk("rst_valid", o_pv_valid, 0);
        chk("rst_addr", o_pv_addr, 0);
        chk("rst_data", o_pv_data, 0);
        chk("rst_req", o_retrain_req, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_full", o_fifo_full, 0);
        i_rst_n = 1'b1;
        tick();

        // 1: three writes streamed through with ready high
        i_pv_ready = 1'b1;
        wr(8'h10, 32'hA5A5A5A5); tick();
        chk("t1_valid0", o_pv_valid, 1);
        chk("t1_addr0", o_pv_addr, 8'h10);
        chk("t1_data0", o_pv_data, 32'hA5A5A5A5);
        wr(8'h14, 32'h1); tick();
        chk("t1_addr1", o_pv_addr, 8'h14);
        chk("t1_data1", o_pv_data, 32'h1);
        chk("t1_count1", o_count, 1);
        wr(8'h18, 32'h2); tick();
        chk("t1_addr2", o_pv_addr, 8'h18);
        chk("t1_data2", o_pv_data, 32'h2);
        idle_wr(); tick();
        chk("t1_count_end", o_count, 0);
        chk("t1_valid_end", o_pv_valid, 0);

        // 2: fill with ready low, fifth write dropped
        i_pv_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(8'h20 + 8'(i), 32'(i)); tick();
        end
        chk("t2_full", o_fifo_full, 1);
        chk("t2_count4", o_count, 4);
        chk("t2_ovf_pre", o_overflow, 0);
        wr(8'h24, 32'h4); tick();
        chk("t2_ovf_set", o_overflow, 1);
        chk("t2_count_hold", o_count, 4);
        idle_wr(); i_ovf_clr = 1'b1; tick();
        i_ovf_clr = 1'b0;
        chk("t2_ovf_clr", o_overflow, 0);
        chk("t2_head", o_pv_addr, 8'h20);

        // 3: push and pop together on a full FIFO
        i_pv_ready = 1'b1;
        wr(8'h40, 32'h40); tick();
        chk("t3_count", o_count, 4);
        chk("t3_ovf", o_overflow, 0);
        chk("t3_head", o_pv_addr, 8'h21);
        idle_wr(); tick();
        chk("t3_head22", o_pv_addr, 8'h22);
        tick();
        chk("t3_head23", o_pv_addr, 8'h23);
        tick();
        chk("t3_head40", o_pv_addr, 8'h40);
        chk("t3_data40", o_pv_data, 32'h40);
        chk("t3_count1", o_count, 1);
        tick();
        chk("t3_empty", o_count, 0);

        // 4: retrain waits for earlier writes, holds later ones
        i_pv_ready = 1'b0;
        wr(8'h50, 32'h5); tick();
        wr(8'h54, 32'h6); tick();
        idle_wr(); i_retrain = 1'b1; tick();
        chk("t4_req_wait0", o_retrain_req, 0);
        tick();
        chk("t4_req_wait1", o_retrain_req, 0);
        chk("t4_count2", o_count, 2);
        i_pv_ready = 1'b1; tick();
        chk("t4_req_wait2", o_retrain_req, 0);
        chk("t4_head54", o_pv_addr, 8'h54);
        tick();
        chk("t4_drained", o_count, 0);
        tick();
        chk("t4_req", o_retrain_req, 1);
        chk("t4_valid_off", o_pv_valid, 0);
        wr(8'h60, 32'h7); tick();
        idle_wr(); tick();
        chk("t4_held_count", o_count, 1);
        chk("t4_held_valid", o_pv_valid, 0);
        chk("t4_req_hold", o_retrain_req, 1);

        // 5: retrain edge during REQ is coalesced
        i_retrain = 1'b0; tick();
        i_retrain = 1'b1; tick();
        chk("t5_req_still", o_retrain_req, 1);
        i_retrain_ack = 1'b1; tick();
        i_retrain_ack = 1'b0;
        chk("t5_req_drop", o_retrain_req, 0);
        chk("t5_valid_back", o_pv_valid, 1);
        chk("t5_head60", o_pv_addr, 8'h60);
        tick();
        chk("t5_delivered", o_count, 0);
        tick(); tick();
        chk("t5_no_second", o_retrain_req, 0);
        i_retrain_ack = 1'b1; tick();
        i_retrain_ack = 1'b0; tick(); tick();
        chk("t5_ack_idle", o_retrain_req, 0);

        // 6: reset in DRAIN, retrain held high across reset
        i_pv_ready = 1'b0; i_retrain = 1'b0; tick();
        wr(8'h70, 32'h70); tick();
        wr(8'h71, 32'h71); tick();
        wr(8'h72, 32'h72); tick();
        idle_wr(); i_retrain = 1'b1; tick();
        chk("t6_count3", o_count, 3);
        chk("t6_req_drain", o_retrain_req, 0);
        i_rst_n = 1'b0; tick();
        chk("t6_rst_count", o_count, 0);
        chk("t6_rst_valid", o_pv_valid, 0);
        chk("t6_rst_req", o_retrain_req, 0);
        i_rst_n = 1'b1; tick();
        chk("t6_req_pre", o_retrain_req, 0);
        tick();
        chk("t6_req_after", o_retrain_req, 1);
        i_retrain_ack = 1'b1; tick();
        i_retrain_ack = 1'b0;
        chk("t6_req_ack", o_retrain_req, 0);
        tick(); tick();
        chk("t6_only_one", o_retrain_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ucie_ctl_phy_wr_bridge.md
Name: ucie_ctl_phy_wr_bridge

Overview:
Downstream stage of the controller CSR block. Consumes the CSR's PHY write-forward strobe (o_phy_WR / o_phy_addr / o_phy_WDATA) and its o_retrain output. Buffers forwarded writes in a small FIFO and delivers them to the PHY register port over a valid/ready handshake. Converts the retrain level into an ordered request/ack handshake that fires only after all earlier writes have reached the PHY.

Parameters:
ADDR_WIDTH, 8, PHY register address width (matches CSR o_phy_addr)
DATA_WIDTH, 32, PHY register data width (matches CSR o_phy_WDATA)
FIFO_DEPTH, 4, write buffer entries; power of 2, >= 2

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_phy_WR  input  1  write strobe from CSR; each high cycle = one write
i_phy_addr  input  ADDR_WIDTH  write address from CSR
i_phy_WDATA  input  DATA_WIDTH  write data from CSR
i_retrain  input  1  retrain level from CSR o_retrain
o_pv_valid  output  1  PHY write valid
o_pv_addr  output  ADDR_WIDTH  PHY write address (FIFO head)
o_pv_data  output  DATA_WIDTH  PHY write data (FIFO head)
i_pv_ready  input  1  PHY accepts head when valid & ready
o_retrain_req  output  1  retrain request to PHY
i_retrain_ack  input  1  PHY retrain acknowledge
o_fifo_full  output  1  count == FIFO_DEPTH
o_count  output  log2(FIFO_DEPTH)+1  current occupancy
o_overflow  output  1  sticky: a write was dropped
i_ovf_clr  input  1  clears o_overflow

Behaviour:
- One clock, i_clk. i_rst_n is synchronous and active-low.
- Reset (sampled low at a posedge), including mid-operation:
  - FIFO flushed, pointers = 0, o_count = 0.
  - o_pv_valid = 0; o_pv_addr and o_pv_data = 0.
  - o_retrain_req = 0, state = IDLE, o_overflow = 0.
  - The retrain edge-detect register resets to 0, so i_retrain held high across reset produces one retrain after reset.
- Push: i_phy_WR = 1 and (count < FIFO_DEPTH or a pop occurs in the same cycle) writes {addr, data} at the write pointer.
- Drop: i_phy_WR = 1, FIFO full, no pop that cycle. The write is discarded and o_overflow is set the next cycle.
- o_overflow priority: set beats i_ovf_clr in the same cycle.
- Pop: o_pv_valid & i_pv_ready.
- Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Latency: a write strobed at edge N into an empty FIFO gives o_pv_valid = 1 after edge N; no bypass. Throughput is 1 write per cycle.
- o_pv_valid = (count != 0) & (state != REQ). o_pv_addr and o_pv_data come from the head entry and hold stable while valid & !ready.
- Retrain FSM:
  - IDLE: a rising edge of i_retrain (i_retrain & !prev) goes to DRAIN. drain_cnt loads count plus 1 if a push happens this cycle, minus 1 if a pop happens this cycle. Writes strobed in the same cycle as the edge are ordered before the retrain.
  - DRAIN: drain_cnt decrements on each pop. When drain_cnt == 0, go to REQ; this includes the entry cycle, so an empty FIFO goes to REQ on the next edge. Pushes are still accepted but are not counted in drain_cnt.
  - REQ: o_retrain_req = 1 and o_pv_valid is forced 0, so the PHY is held off during retrain. On i_retrain_ack = 1, go to IDLE; o_retrain_req drops after that edge and draining resumes.
- i_retrain edges seen in DRAIN or REQ are ignored (coalesced). i_retrain_ack outside REQ is ignored.
- o_fifo_full and o_count are registered-state derived and contain no combinational path from inputs.

Test Plan:
1. Reset, strobe 3 writes (0x10/0xA5A5A5A5, 0x14/0x1, 0x18/0x2) with i_pv_ready = 1 -> o_pv_valid first high after the first strobe edge; PHY sees the 3 writes in order, one per cycle; o_count returns to 0.
2. i_pv_ready = 0, strobe 5 writes with FIFO_DEPTH = 4 -> o_fifo_full = 1 after the 4th, 5th dropped, o_overflow = 1. Pulse i_ovf_clr -> o_overflow = 0. Drain -> only the first 4 writes arrive.
3. Full FIFO, i_pv_ready = 1 and i_phy_WR = 1 in the same cycle -> push accepted, o_count stays 4, o_overflow stays 0.
4. i_pv_ready = 0, 2 writes queued, then i_retrain rises -> o_retrain_req stays 0. Raise i_pv_ready -> both writes popped, then o_retrain_req = 1 and o_pv_valid = 0. A write strobed during REQ is held. i_retrain_ack -> request drops, held write delivered.
5. In REQ, toggle i_retrain again -> no second request after ack. i_retrain_ack in IDLE -> no effect.
6. Assert i_rst_n = 0 in DRAIN with 3 entries queued -> next cycle o_count = 0, o_pv_valid = 0, o_retrain_req = 0. i_retrain still high -> one retrain request after reset release.
